// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 constants for the keyboard path: receiver, translator and top level.
package ps2_pkg;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;

   localparam logic [7:0] ASCII_NUL = 8'h00;

endpackage

// File: rtl/tran_ascii.sv
// Set-2 scan byte to unshifted ASCII, registered once. Prefix bytes, modifiers and
// unknown codes all fall to NUL; release tracking lives in the top level.
module tran_ascii
   import ps2_pkg::*;
(
   input  logic       i_gclk,
   input  logic       i_grst_n,
   input  logic [7:0] i_scan_code,
   output logic [7:0] o_ascii_code
);

   logic [7:0] w_ascii;
   logic [7:0] r_ascii;

   always_comb begin
      w_ascii = ASCII_NUL;
      case (i_scan_code)
         8'h1C: w_ascii = 8'h61;
         8'h32: w_ascii = 8'h62;
         8'h21: w_ascii = 8'h63;
         8'h23: w_ascii = 8'h64;
         8'h24: w_ascii = 8'h65;
         8'h2B: w_ascii = 8'h66;
         8'h34: w_ascii = 8'h67;
         8'h33: w_ascii = 8'h68;
         8'h43: w_ascii = 8'h69;
         8'h3B: w_ascii = 8'h6A;
         8'h42: w_ascii = 8'h6B;
         8'h4B: w_ascii = 8'h6C;
         8'h3A: w_ascii = 8'h6D;
         8'h31: w_ascii = 8'h6E;
         8'h44: w_ascii = 8'h6F;
         8'h4D: w_ascii = 8'h70;
         8'h15: w_ascii = 8'h71;
         8'h2D: w_ascii = 8'h72;
         8'h1B: w_ascii = 8'h73;
         8'h2C: w_ascii = 8'h74;
         8'h3C: w_ascii = 8'h75;
         8'h2A: w_ascii = 8'h76;
         8'h1D: w_ascii = 8'h77;
         8'h22: w_ascii = 8'h78;
         8'h35: w_ascii = 8'h79;
         8'h1A: w_ascii = 8'h7A;
         // digit row
         8'h45: w_ascii = 8'h30;
         8'h16: w_ascii = 8'h31;
         8'h1E: w_ascii = 8'h32;
         8'h26: w_ascii = 8'h33;
         8'h25: w_ascii = 8'h34;
         8'h2E: w_ascii = 8'h35;
         8'h36: w_ascii = 8'h36;
         8'h3D: w_ascii = 8'h37;
         8'h3E: w_ascii = 8'h38;
         8'h46: w_ascii = 8'h39;
         8'h4E: w_ascii = 8'h2D;
         8'h55: w_ascii = 8'h3D;
         8'h54: w_ascii = 8'h5B;
         8'h5B: w_ascii = 8'h5D;
         8'h5D: w_ascii = 8'h5C;
         8'h4C: w_ascii = 8'h3B;
         8'h52: w_ascii = 8'h27;
         8'h41: w_ascii = 8'h2C;
         8'h49: w_ascii = 8'h2E;
         8'h4A: w_ascii = 8'h2F;
         8'h0E: w_ascii = 8'h60;
         8'h29: w_ascii = 8'h20;
         8'h5A: w_ascii = 8'h0D;
         8'h66: w_ascii = 8'h08;
         8'h0D: w_ascii = 8'h09;
         8'h76: w_ascii = 8'h1B;
         default: w_ascii = ASCII_NUL;
      endcase
   end

   always_ff @(posedge i_gclk or negedge i_grst_n) begin
      if (!i_grst_n) r_ascii <= ASCII_NUL;
      else           r_ascii <= w_ascii;
   end

   assign o_ascii_code = r_ascii;

endmodule

// File: tb/tb_tran_ascii.sv
// Bench for tran_ascii: vector table through a one-cycle scoreboard, plus reset,
// break-sequence and hold sequences.
module tb_tran_ascii;

   logic       gclk = 1'b0;
   logic       grst_n = 1'b0;
   logic [7:0] scan = 8'h00;
   logic [7:0] ascii;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] code;
      logic [7:0] exp;
   } vec_t;

   vec_t       vecs [0:79];
   int         nvec = 0;
   logic [7:0] sb_q [$];

   tran_ascii dut (
      .i_gclk      (gclk),
      .i_grst_n    (grst_n),
      .i_scan_code (scan),
      .o_ascii_code(ascii)
   );

   always #5 gclk = ~gclk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [7:0] c, input logic [7:0] e);
      vecs[nvec].code = c;
      vecs[nvec].exp  = e;
      nvec++;
   endtask

   // drive a byte, push its translation, pop and compare one edge later
   task automatic apply(input string name, input logic [7:0] c, input logic [7:0] e);
      logic [7:0] want;
      scan = c;
      sb_q.push_back(e);
      @(posedge gclk);
      #1;
      want = sb_q.pop_front();
      chk($sformatf("%s sc=%h", name, c), ascii, want);
   endtask

   initial begin
      logic [7:0] letters [0:25];
      logic [7:0] prev;
      int         trans;
      letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
      for (int i = 0; i < 26; i++) add(letters[i], 8'h61 + 8'(i));
      add(8'h45, "0"); add(8'h16, "1"); add(8'h1E, "2"); add(8'h26, "3");
      add(8'h25, "4"); add(8'h2E, "5"); add(8'h36, "6"); add(8'h3D, "7");
      add(8'h3E, "8"); add(8'h46, "9");
      add(8'h4E, "-"); add(8'h55, "="); add(8'h54, "["); add(8'h5B, "]");
      add(8'h5D, 8'h5C); add(8'h4C, ";"); add(8'h52, 8'h27); add(8'h41, ",");
      add(8'h49, "."); add(8'h4A, "/"); add(8'h0E, 8'h60);
      add(8'h29, 8'h20); add(8'h5A, 8'h0D); add(8'h66, 8'h08);
      add(8'h0D, 8'h09); add(8'h76, 8'h1B);
      add(8'hE0, 8'h00); add(8'h12, 8'h00); add(8'h59, 8'h00); add(8'h14, 8'h00);
      add(8'h11, 8'h00); add(8'h58, 8'h00); add(8'h05, 8'h00); add(8'hFF, 8'h00);
      add(8'h00, 8'h00); add(8'hF0, 8'h00);

      // reset held from time 0
      repeat (2) @(posedge gclk);
      #1 chk("reset_initial", ascii, 8'h00);
      grst_n = 1'b1;
      apply("pre_reset_load", 8'h1C, 8'h61);

      // asynchronous assert mid-cycle with 'a' present
      #3 grst_n = 1'b0;
      #1 chk("reset_async", ascii, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(posedge gclk);
         #1 chk($sformatf("reset_hold%0d", i), ascii, 8'h00);
      end
      #2 grst_n = 1'b1;
      #1 chk("reset_release_pre_edge", ascii, 8'h00);
      @(posedge gclk);
      #1 chk("reset_release_load", ascii, 8'h61);

      for (int i = 0; i < nvec; i++) apply($sformatf("vec%0d", i), vecs[i].code, vecs[i].exp);

      apply("brk0", 8'h1C, 8'h61);
      apply("brk1", 8'hF0, 8'h00);
      apply("brk2", 8'h1C, 8'h61);

      // hold 4E; also probe mid-cycle to catch any transition
      scan = 8'h4E;
      @(posedge gclk);
      #1 prev = ascii;
      chk("hold_first", ascii, 8'h2D);
      trans = 0;
      for (int i = 0; i < 9; i++) begin
         #3 if (ascii !== prev) trans++;
         @(posedge gclk);
         #1 chk($sformatf("hold%0d", i), ascii, 8'h2D);
         if (ascii !== prev) trans++;
         prev = ascii;
      end
      chk("hold_transitions", 8'(trans), 8'h00);

      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
